// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
// Optional FETCH_PERF_EN adds performance counters in the top level.
package fetch_pc_gen_pkg;

    typedef logic [31:0] addr_t;

    typedef enum logic {
        SEQ     = 1'b0,
        WAIT_DS = 1'b1
    } fetch_state_t;

    localparam int unsigned FETCH_GROUP_BYTES = 8;

    // Start of the next aligned fetch group; wraps from 32'hffff_fff8 to 0.
    function automatic addr_t seq_pc(input addr_t pc);
        addr_t base;
        base = {pc[31:3], 3'b000};
        return base + addr_t'(FETCH_GROUP_BYTES);
    endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch request, predictor and redirect signals shared by the PC generator
// and its neighbours (I-cache, branch predictor, execute, exception unit).
interface fetch_pc_gen_if;
    import fetch_pc_gen_pkg::*;

    logic  ireq_valid;
    addr_t ireq_addr;
    logic  ireq_ready;
    addr_t f1_pc;
    logic  f1_taken;
    logic  pos;
    addr_t pre_pc;
    logic  f1_ds_only;
    logic  f1_pred_taken;
    addr_t f1_pred_target;
    logic  exe_redir;
    addr_t exe_redir_pc;
    logic  excp_redir;
    addr_t excp_redir_pc;

    modport master (
        output ireq_valid, ireq_addr, f1_pc, f1_ds_only, f1_pred_taken, f1_pred_target,
        input  ireq_ready, f1_taken, pos, pre_pc, exe_redir, exe_redir_pc,
               excp_redir, excp_redir_pc
    );

    modport slave (
        input  ireq_valid, ireq_addr, f1_pc, f1_ds_only, f1_pred_taken, f1_pred_target,
        output ireq_ready, f1_taken, pos, pre_pc, exe_redir, exe_redir_pc,
               excp_redir, excp_redir_pc
    );

endinterface

// File: rtl/fetch_pc_gen_perf_cnt.sv
// Prediction / execute-redirect event counters; only built when FETCH_PERF_EN
// is defined. Counters wrap and clear on synchronous reset.
`ifdef FETCH_PERF_EN
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_pred_inc,
    input  logic        i_redir_inc,
    output logic [31:0] o_pred_cnt,
    output logic [31:0] o_redir_cnt
);

    logic [31:0] r_pred_cnt;
    logic [31:0] r_redir_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pred_cnt  <= '0;
            r_redir_cnt <= '0;
        end else begin
            if (i_pred_inc)  r_pred_cnt  <= r_pred_cnt + 32'd1;
            if (i_redir_inc) r_redir_cnt <= r_redir_cnt + 32'd1;
        end
    end

    assign o_pred_cnt  = r_pred_cnt;
    assign o_redir_cnt = r_redir_cnt;

endmodule
`endif

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: next-PC selection with MIPS delay-slot handling.
// Define FETCH_PERF_EN to add perf_pred_cnt / perf_redir_cnt outputs.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter addr_t RESET_PC = 32'hbfc0_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_pc_gen_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_pred_cnt,
    output logic [31:0]   perf_redir_cnt
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    addr_t        r_pc;
    addr_t        w_next_pc;
    addr_t        r_tgt;
    addr_t        w_next_tgt;
    logic         r_valid;
    logic         w_accept;
    logic         w_pred_taken;
    addr_t        w_pred_target;
    addr_t        w_seq_pc;

    assign w_accept = r_valid & bus.ireq_ready;
    assign w_seq_pc = seq_pc(r_pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEQ;
            r_pc    <= RESET_PC;
            r_tgt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_tgt   <= w_next_tgt;
            r_valid <= 1'b1;
        end
    end

    // Redirects win over the handshake; a stalled request simply holds everything.
    always_comb begin
        w_next_state  = r_state;
        w_next_pc     = r_pc;
        w_next_tgt    = r_tgt;
        w_pred_taken  = 1'b0;
        w_pred_target = '0;

        if (bus.excp_redir) begin
            w_next_pc    = bus.excp_redir_pc;
            w_next_state = SEQ;
            w_next_tgt   = '0;
        end else if (bus.exe_redir) begin
            w_next_pc    = bus.exe_redir_pc;
            w_next_state = SEQ;
            w_next_tgt   = '0;
        end else if (w_accept) begin
            case (r_state)
                SEQ: begin
                    w_next_pc = w_seq_pc;
                    if (bus.f1_taken && bus.pos && !r_pc[2]) begin
                        w_next_pc     = bus.pre_pc;
                        w_pred_taken  = 1'b1;
                        w_pred_target = bus.pre_pc;
                    end else if (bus.f1_taken) begin
                        // Delay slot lives in the next group: fetch it before jumping.
                        w_next_tgt   = bus.pre_pc;
                        w_next_state = WAIT_DS;
                    end
                end
                WAIT_DS: begin
                    w_next_pc     = r_tgt;
                    w_next_tgt    = '0;
                    w_next_state  = SEQ;
                    w_pred_taken  = 1'b1;
                    w_pred_target = r_tgt;
                end
                default: begin
                    w_next_state = SEQ;
                end
            endcase
        end
    end

    assign bus.ireq_valid     = r_valid;
    assign bus.ireq_addr      = r_pc;
    assign bus.f1_pc          = r_pc;
    assign bus.f1_ds_only     = (r_state == WAIT_DS);
    assign bus.f1_pred_taken  = w_pred_taken;
    assign bus.f1_pred_target = w_pred_target;

`ifdef FETCH_PERF_EN
    fetch_perf_cnt u_perf (
        .clk         (clk),
        .reset       (reset),
        .i_pred_inc  (w_pred_taken),
        .i_redir_inc (bus.exe_redir),
        .o_pred_cnt  (perf_pred_cnt),
        .o_redir_cnt (perf_redir_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: reset, sequential fetch, predictions,
// delay-slot wait with stalls, redirect priority, wrap-around, perf counters.
module tb_fetch_pc_gen;
    import fetch_pc_gen_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    fetch_pc_gen_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_pred_cnt;
    logic [31:0] perf_redir_cnt;
`endif

    fetch_pc_gen dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_pred_cnt  (perf_pred_cnt),
        .perf_redir_cnt (perf_redir_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ireq_ready    = 1'b1;
        bus.f1_taken      = 1'b0;
        bus.pos           = 1'b0;
        bus.pre_pc        = '0;
        bus.exe_redir     = 1'b0;
        bus.exe_redir_pc  = '0;
        bus.excp_redir    = 1'b0;
        bus.excp_redir_pc = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic goto_pc(input addr_t pc);
        bus.exe_redir    = 1'b1;
        bus.exe_redir_pc = pc;
        tick();
        bus.exe_redir    = 1'b0;
        bus.exe_redir_pc = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (bus.ireq_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got %b want 0", bus.ireq_valid);
        end
        n_vec++;
        if (bus.f1_ds_only !== 1'b0 || bus.f1_pred_taken !== 1'b0 || bus.f1_pred_target !== 32'h0) begin
            n_err++; $display("FAIL reset_tags got ds=%b pt=%b tgt=%h want 0/0/0",
                              bus.f1_ds_only, bus.f1_pred_taken, bus.f1_pred_target);
        end
        tick();
        n_vec++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'hbfc0_0000 || bus.f1_pc !== 32'hbfc0_0000) begin
            n_err++; $display("FAIL first_req got v=%b a=%h pc=%h want 1/bfc00000", bus.ireq_valid,
                              bus.ireq_addr, bus.f1_pc);
        end
        tick();
        n_vec++;
        if (bus.ireq_addr !== 32'hbfc0_0008) begin
            n_err++; $display("FAIL seq1 got %h want bfc00008", bus.ireq_addr);
        end
        tick();
        n_vec++;
        if (bus.ireq_addr !== 32'hbfc0_0010) begin
            n_err++; $display("FAIL seq2 got %h want bfc00010", bus.ireq_addr);
        end
    endtask

    task automatic test_pred_same_group();
        goto_pc(32'h0000_1000);
        n_vec++;
        if (bus.ireq_addr !== 32'h0000_1000) begin
            n_err++; $display("FAIL redir_1000 got %h want 00001000", bus.ireq_addr);
        end
        bus.f1_taken = 1'b1; bus.pos = 1'b1; bus.pre_pc = 32'h0000_2000;
        #1;
        n_vec++;
        if (bus.f1_pred_taken !== 1'b1 || bus.f1_pred_target !== 32'h0000_2000) begin
            n_err++; $display("FAIL pred_tag got pt=%b tgt=%h want 1/00002000",
                              bus.f1_pred_taken, bus.f1_pred_target);
        end
        tick();
        idle_inputs();
        #1;
        n_vec++;
        if (bus.ireq_addr !== 32'h0000_2000 || bus.f1_ds_only !== 1'b0 || bus.f1_pred_taken !== 1'b0) begin
            n_err++; $display("FAIL pred_jump got a=%h ds=%b pt=%b want 00002000/0/0",
                              bus.ireq_addr, bus.f1_ds_only, bus.f1_pred_taken);
        end
    endtask

    task automatic test_pred_odd_slot();
        goto_pc(32'h0000_1004);
        bus.f1_taken = 1'b1; bus.pos = 1'b1; bus.pre_pc = 32'h0000_5000;
        #1;
        n_vec++;
        if (bus.f1_pred_taken !== 1'b0) begin
            n_err++; $display("FAIL odd_tag got %b want 0", bus.f1_pred_taken);
        end
        tick();
        idle_inputs();
        #1;
        n_vec++;
        if (bus.ireq_addr !== 32'h0000_1008 || bus.f1_ds_only !== 1'b1) begin
            n_err++; $display("FAIL odd_ds got a=%h ds=%b want 00001008/1", bus.ireq_addr, bus.f1_ds_only);
        end
        tick();
        n_vec++;
        if (bus.ireq_addr !== 32'h0000_5000 || bus.f1_ds_only !== 1'b0) begin
            n_err++; $display("FAIL odd_jump got a=%h ds=%b want 00005000/0", bus.ireq_addr, bus.f1_ds_only);
        end
    endtask

    task automatic test_wait_ds_stall();
        goto_pc(32'h0000_1000);
        bus.f1_taken = 1'b1; bus.pos = 1'b0; bus.pre_pc = 32'h0000_3000;
        #1;
        n_vec++;
        if (bus.f1_pred_taken !== 1'b0) begin
            n_err++; $display("FAIL ds_tag got %b want 0", bus.f1_pred_taken);
        end
        tick();
        // Predictor garbage in WAIT_DS must be ignored.
        bus.f1_taken = 1'b1; bus.pos = 1'b1; bus.pre_pc = 32'h7777_0000;
        bus.ireq_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (bus.ireq_addr !== 32'h0000_1008 || bus.f1_ds_only !== 1'b1 || bus.f1_pred_taken !== 1'b0) begin
                n_err++; $display("FAIL ds_stall%0d got a=%h ds=%b pt=%b want 00001008/1/0", i,
                                  bus.ireq_addr, bus.f1_ds_only, bus.f1_pred_taken);
            end
            tick();
        end
        bus.ireq_ready = 1'b1;
        #1;
        n_vec++;
        if (bus.f1_pred_taken !== 1'b1 || bus.f1_pred_target !== 32'h0000_3000) begin
            n_err++; $display("FAIL ds_release_tag got pt=%b tgt=%h want 1/00003000",
                              bus.f1_pred_taken, bus.f1_pred_target);
        end
        tick();
        idle_inputs();
        #1;
        n_vec++;
        if (bus.ireq_addr !== 32'h0000_3000 || bus.f1_ds_only !== 1'b0) begin
            n_err++; $display("FAIL ds_jump got a=%h ds=%b want 00003000/0", bus.ireq_addr, bus.f1_ds_only);
        end
    endtask

    task automatic test_redirect_priority();
        goto_pc(32'h0000_1000);
        bus.f1_taken = 1'b1; bus.pos = 1'b0; bus.pre_pc = 32'h0000_3000;
        tick();
        idle_inputs();
        bus.exe_redir = 1'b1;  bus.exe_redir_pc  = 32'h0000_4000;
        bus.excp_redir = 1'b1; bus.excp_redir_pc = 32'hbfc0_0380;
        #1;
        n_vec++;
        if (bus.f1_ds_only !== 1'b1 || bus.f1_pred_taken !== 1'b0) begin
            n_err++; $display("FAIL prio_pre got ds=%b pt=%b want 1/0", bus.f1_ds_only, bus.f1_pred_taken);
        end
        tick();
        idle_inputs();
        #1;
        n_vec++;
        if (bus.ireq_addr !== 32'hbfc0_0380 || bus.f1_ds_only !== 1'b0) begin
            n_err++; $display("FAIL prio_excp got a=%h ds=%b want bfc00380/0", bus.ireq_addr, bus.f1_ds_only);
        end
        tick();
        n_vec++;
        if (bus.ireq_addr !== 32'hbfc0_0388) begin
            n_err++; $display("FAIL prio_after got %h want bfc00388", bus.ireq_addr);
        end
    endtask

    task automatic test_redir_stall_wrap();
        bus.ireq_ready = 1'b0;
        goto_pc(32'h0000_0102);
        n_vec++;
        if (bus.ireq_addr !== 32'h0000_0102) begin
            n_err++; $display("FAIL stall_redir got %h want 00000102", bus.ireq_addr);
        end
        bus.ireq_ready = 1'b1;
        tick();
        n_vec++;
        if (bus.ireq_addr !== 32'h0000_0108) begin
            n_err++; $display("FAIL misalign_seq got %h want 00000108", bus.ireq_addr);
        end
        goto_pc(32'hffff_fff8);
        tick();
        n_vec++;
        if (bus.ireq_addr !== 32'h0000_0000) begin
            n_err++; $display("FAIL wrap got %h want 00000000", bus.ireq_addr);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        tick();
        bus.f1_taken = 1'b1; bus.pos = 1'b1; bus.pre_pc = 32'h0000_2000;
        tick();
        bus.pos = 1'b0; bus.pre_pc = 32'h0000_3000;
        tick();
        idle_inputs();
        tick();
        n_vec++;
        if (bus.ireq_addr !== 32'h0000_3000) begin
            n_err++; $display("FAIL perf_path got %h want 00003000", bus.ireq_addr);
        end
        goto_pc(32'h0000_4000);
        n_vec++;
        if (perf_pred_cnt !== 32'd2 || perf_redir_cnt !== 32'd1) begin
            n_err++; $display("FAIL perf_cnt got pred=%0d redir=%0d want 2/1", perf_pred_cnt, perf_redir_cnt);
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_pred_same_group();
        test_pred_odd_slot();
        test_wait_ds_stall();
        test_redirect_priority();
        test_redir_stall_wrap();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
